adder_rr_arbiter: RTL

Round-robin arbiter and sequencer that shares one 4-bit `Ripple_Carry_Adder` instance among `N_REQ` requesters. It accepts operand requests, grants one requester at a time, registers that requester's operands into the adder, and returns the registered Sum/Carry_Out over a valid/ready response channel tagged with the requester index. It sits between the requesting datapath blocks and the single shared adder, which it instantiates internally.

---
 rtl/adder_rr_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin front end that lets N_REQ requesters share
// one 4-bit ripple-carry adder, with a registered valid/ready response.
//
// state | meaning
// IDLE  | nothing in flight; arbitrate among req on every edge
// EXEC  | operands registered, shared adder settling; result captured next edge
// RESP  | response presented on rsp_*; wait for rsp_ready
module adder_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] a_bus,
  input  logic [4*N_REQ-1:0] b_bus,
  input  logic [N_REQ-1:0]   cin_bus,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [3:0]         rsp_sum,
  output logic               rsp_cout
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [3:0]       rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic [3:0]       op_a_q, op_a_d;
  logic [3:0]       op_b_q, op_b_d;
  logic             op_cin_q, op_cin_d;

  logic             win_found;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  cand;
  logic [3:0]       add_sum;
  logic             add_cout;

  // Shared adder always works from the registered operands, never from the buses.
  Ripple_Carry_Adder u_adder (
    .A        (op_a_q),
    .B        (op_b_q),
    .Carry_In (op_cin_q),
    .Sum      (add_sum),
    .Carry_Out(add_cout)
  );

  // Find the first requester at or after ptr, wrapping at N_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  // Next-state and next-output logic; grant is a single-cycle pulse.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          op_a_d            = a_bus[{win_idx, 2'b00} +: 4];
          op_b_d            = b_bus[{win_idx, 2'b00} +: 4];
          op_cin_d          = cin_bus[win_idx];
          rsp_id_d          = win_idx;
          grant_d[win_idx]  = 1'b1;
          ptr_d             = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d           = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = add_sum;
        rsp_cout_d  = add_cout;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
endmodule

// Ripple_Carry_Adder: 4-bit adder built from a chain of full adders.
module Ripple_Carry_Adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Carry_In,
  output logic [3:0] Sum,
  output logic       Carry_Out
);
  logic [4:0] carry;

  assign carry[0] = Carry_In;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Carry_Out = carry[4];
endmodule
